// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets, STATUS bit
// positions and the transmit FSM state encoding.
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_PAR       = 4;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } txState_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bus as seen by an MMIO responder: word address, write data,
// byte-lane mask and write strobe from the CPU, registered read data back.
interface mmio_uart_tx_if;
    logic [29:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_mask;
    logic        mmio_wren;
    logic [31:0] mmio_rdata;

    modport master (output mmio_addr, mmio_wdata, mmio_mask, mmio_wren, input mmio_rdata);
    modport slave  (input mmio_addr, mmio_wdata, mmio_mask, mmio_wren, output mmio_rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry. When full, a pop in
// the same cycle frees a slot so the concurrent push is accepted.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPop;
    logic             w_doPush;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_level  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: 4-word register window, byte FIFO and serial TX FSM.
// Define UART_TX_PARITY_EN for 8E1 frames (even-parity bit between DATA and STOP).
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR   = 30'h0400_0000,
    parameter logic [15:0] CLK_DIV_RST = 16'd434,
    parameter int          FIFO_AW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_tx_if.slave        bus,
    output logic                 o_tx
);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic [29:0]      w_offset;
    logic             w_hit;
    logic [1:0]       w_reg;
    logic             w_wrTx;
    logic             w_wrStatus;
    logic             w_wrDiv;
    logic [7:0]       w_fifoData;
    logic             w_full;
    logic             w_empty;
    logic [FIFO_AW:0] w_level;
    logic             w_pop;
    logic             w_bitEnd;
    logic [15:0]      w_nextBitDiv;
    logic [31:0]      w_status;

    logic [15:0] r_div;
    logic        r_ovf;
    logic [31:0] r_rdata;
    txState_t    r_state;
    logic        r_tx;
    logic [15:0] r_baud;
    logic [15:0] r_bitDiv;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    // Offset arithmetic keeps the decode correct for any BASE_ADDR alignment.
    assign w_offset   = bus.mmio_addr - BASE_ADDR;
    assign w_hit      = (w_offset[29:2] == '0);
    assign w_reg      = w_offset[1:0];
    assign w_wrTx     = bus.mmio_wren && w_hit && (w_reg == REG_TXDATA) && bus.mmio_mask[0];
    assign w_wrStatus = bus.mmio_wren && w_hit && (w_reg == REG_STATUS) && bus.mmio_mask[0];
    assign w_wrDiv    = bus.mmio_wren && w_hit && (w_reg == REG_DIV);

    assign w_bitEnd     = (r_baud == r_bitDiv - 16'd1);
    assign w_nextBitDiv = (r_div == '0) ? 16'd1 : r_div;
    assign w_pop        = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bitEnd));

    assign o_tx           = r_tx;
    assign bus.mmio_rdata = r_rdata;

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wrTx),
        .i_data  (bus.mmio_wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifoData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_status                       = '0;
        w_status[STAT_BUSY]            = (r_state != ST_IDLE);
        w_status[STAT_FULL]            = w_full;
        w_status[STAT_EMPTY]           = w_empty;
        w_status[STAT_OVF]             = r_ovf;
        w_status[STAT_PAR]             = PARITY_EN;
        w_status[STAT_LEVEL_LSB +: 8]  = 8'(w_level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= CLK_DIV_RST;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wrDiv && bus.mmio_mask[0]) r_div[7:0]  <= bus.mmio_wdata[7:0];
            if (w_wrDiv && bus.mmio_mask[1]) r_div[15:8] <= bus.mmio_wdata[15:8];
            // A push into a full FIFO is only lost when the FSM is not popping the same cycle.
            if (w_wrTx && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wrStatus && bus.mmio_wdata[STAT_OVF])
                r_ovf <= 1'b0;
            r_rdata <= '0;
            if (w_hit) begin
                case (w_reg)
                    REG_STATUS: r_rdata <= w_status;
                    REG_DIV:    r_rdata <= {16'h0000, r_div};
                    default:    r_rdata <= '0;
                endcase
            end
        end
    end

    // Bit length is latched at every bit boundary so DIV writes never stretch the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tx     <= 1'b1;
            r_baud   <= '0;
            r_bitDiv <= 16'd1;
            r_bitIdx <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            if (r_state != ST_IDLE) begin
                if (w_bitEnd) begin
                    r_baud   <= '0;
                    r_bitDiv <= w_nextBitDiv;
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift  <= w_fifoData;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifoData;
`endif
                        r_tx     <= 1'b0;
                        r_baud   <= '0;
                        r_bitDiv <= w_nextBitDiv;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bitEnd) begin
                        r_tx     <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitIdx <= '0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bitEnd) begin
                        if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bitEnd) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bitEnd) begin
                        if (!w_empty) begin
                            r_shift  <= w_fifoData;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_fifoData;
`endif
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: bytes written are queued as expected frames
// and compared cycle by cycle against o_tx; register reads checked against constants.
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    localparam logic [29:0] BASE = 30'h0400_0000;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [31:0] PAR_BIT    = 32'h10;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [31:0] PAR_BIT    = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLK_DIV_RST (16'd434),
        .FIFO_AW     (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .o_tx (tx)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  expQ[$];
    logic [15:0] curDiv = 16'd434;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        failures++;
        $error("[TB] FAIL %s: observed timeout expected frame start", tag);
    endtask

    // All bus tasks start and end on a falling edge so consecutive calls are back-to-back.
    task automatic writeReg(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m);
        bus.mmio_addr  = BASE + 30'(off);
        bus.mmio_wdata = d;
        bus.mmio_mask  = m;
        bus.mmio_wren  = 1'b1;
        @(negedge clk);
        bus.mmio_wren  = 1'b0;
        bus.mmio_mask  = 4'h0;
    endtask

    task automatic readAddr(input logic [29:0] a, output logic [31:0] d);
        bus.mmio_addr = a;
        @(negedge clk);
        d = bus.mmio_rdata;
    endtask

    task automatic setDiv(input logic [15:0] div);
        writeReg(REG_DIV, {16'h0, div}, 4'h3);
        curDiv = div;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit accepted);
        writeReg(REG_TXDATA, {24'h0, b}, 4'h1);
        if (accepted) expQ.push_back(b);
    endtask

    task automatic receiveFrame(input bit waitStart);
        logic [7:0]  b;
        logic [10:0] bits;
        int          bitCycles;
        int          cyc;
        if (expQ.size() == 0) begin
            timeoutFail("scoreboard empty");
            return;
        end
        b         = expQ.pop_front();
        bitCycles = (curDiv == 16'd0) ? 1 : int'(curDiv);
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^b;
`endif
        bus.mmio_addr = BASE + 30'(REG_STATUS);
        if (waitStart) begin
            cyc = 0;
            while (tx !== 1'b0 && cyc < (FRAME_BITS + 4) * bitCycles + 20) begin
                @(negedge clk);
                cyc++;
            end
            if (tx !== 1'b0) begin
                timeoutFail($sformatf("start of frame 0x%02h", b));
                return;
            end
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int c = 0; c < bitCycles; c++) begin
                checkOutput($sformatf("frame 0x%02h bit %0d cyc %0d", b, i, c), 32'(tx), 32'(bits[i]));
                if (c == bitCycles / 2 && (i > 0 || c > 0))
                    checkOutput($sformatf("busy frame 0x%02h bit %0d", b, i),
                                32'(bus.mmio_rdata[STAT_BUSY]), 32'h1);
                @(negedge clk);
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        curDiv = 16'd434;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          zeros;

        bus.mmio_addr  = '0;
        bus.mmio_wdata = '0;
        bus.mmio_mask  = '0;
        bus.mmio_wren  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and register window decode.
        checkOutput("reset tx", 32'(tx), 32'h1);
        checkOutput("reset rdata", bus.mmio_rdata, 32'h0);
        readAddr(BASE + 30'd1, rd);  checkOutput("reset status", rd, 32'h4 | PAR_BIT);
        readAddr(BASE + 30'd2, rd);  checkOutput("reset div", rd, 32'h0000_01B2);
        readAddr(BASE + 30'd0, rd);  checkOutput("txdata reads 0", rd, 32'h0);
        readAddr(BASE + 30'd3, rd);  checkOutput("rsvd reads 0", rd, 32'h0);
        readAddr(BASE + 30'd8, rd);  checkOutput("outside +8", rd, 32'h0);
        readAddr(BASE - 30'd1, rd);  checkOutput("outside -1", rd, 32'h0);

        // Single frame at DIV=4.
        setDiv(16'd4);
        readAddr(BASE + 30'd2, rd);  checkOutput("div=4", rd, 32'h4);
        applyStimulus(8'h55, 1'b1);
        receiveFrame(1'b1);

        // Back-to-back frames: the second must start right after the first stop bit.
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h42, 1'b1);
        receiveFrame(1'b1);
        receiveFrame(1'b0);
        readAddr(BASE + 30'd1, rd);  checkOutput("idle status", rd, 32'h4 | PAR_BIT);
        checkOutput("idle tx", 32'(tx), 32'h1);

        // DIV=0 behaves as one cycle per bit.
        setDiv(16'd0);
        applyStimulus(8'hC3, 1'b1);
        receiveFrame(1'b1);

        // Byte-lane masking on DIV.
        writeReg(REG_DIV, 32'hFFFF_FF07, 4'b0001);
        readAddr(BASE + 30'd2, rd);  checkOutput("div lane0", rd, 32'h0007);
        writeReg(REG_DIV, 32'h1234_0A99, 4'b0010);
        readAddr(BASE + 30'd2, rd);  checkOutput("div lane1", rd, 32'h0A07);

        // Overflow: the first byte goes straight into the shifter, so 17 writes fill
        // the 16-entry FIFO and the 18th is dropped.
        setDiv(16'd100);
        for (int i = 0; i < 18; i++) applyStimulus(8'(i + 1), i < 17);
        readAddr(BASE + 30'd1, rd);  checkOutput("full+ovf", rd, 32'h100B | PAR_BIT);
        writeReg(REG_STATUS, 32'h0, 4'h1);
        readAddr(BASE + 30'd1, rd);  checkOutput("ovf kept", rd, 32'h100B | PAR_BIT);
        writeReg(REG_STATUS, 32'h8, 4'h1);
        readAddr(BASE + 30'd1, rd);  checkOutput("ovf cleared", rd, 32'h1003 | PAR_BIT);
        doReset();
        readAddr(BASE + 30'd1, rd);  checkOutput("flush status", rd, 32'h4 | PAR_BIT);
        readAddr(BASE + 30'd2, rd);  checkOutput("div after reset", rd, 32'h0000_01B2);

        // Reset in the middle of data bit 3 of 0xA5 (a 0 bit) with a second byte queued.
        setDiv(16'd4);
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h3C, 1'b0);
        zeros = 0;
        while (tx !== 1'b0 && zeros < 40) begin
            @(negedge clk);
            zeros++;
        end
        repeat (18) @(negedge clk);
        checkOutput("bit3 before reset", 32'(tx), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("tx after reset", 32'(tx), 32'h1);
        rst = 1'b0;
        expQ.delete();
        curDiv = 16'd434;
        readAddr(BASE + 30'd1, rd);  checkOutput("status after reset", rd, 32'h4 | PAR_BIT);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        checkOutput("no resumed frame", 32'(zeros), 32'h0);
        setDiv(16'd4);
        applyStimulus(8'h5A, 1'b1);
        receiveFrame(1'b1);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        applyStimulus(8'h07, 1'b1);
        receiveFrame(1'b1);
`endif

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
